wb_cdb_arbiter: RTL and testbench
=================================

// Module: wb_cdb_arbiter
// PURPOSE
// - Writeback end of the register-file write port: collects completed results from NUM_FU functional units.
// - Grants one result per cycle, round-robin, and drives the register-file write port (reg_write/Write_reg/Write_Data).
// - Broadcasts the same result on the common data bus (cdb_*) for reservation-station and ROB wakeup.
// - Each FU has a one-entry holding buffer, so an FU can retire into its buffer while waiting for grant.
// PARAMETERS
// - NUM_FU  4   number of functional-unit requesters (>=2)
// - ADDR    5   register index width (matches register file)
// - WIDTH   32  data width
// - TAG_W   6   ROB/instruction tag width
// PORTS
// - clk        in   1                clock, all state updates on rising edge
// - rst        in   1                synchronous, active-high reset
// - flush      in   1                synchronous pipeline flush (mispredict)
// - fu_valid   in   NUM_FU           FU i presents a result this cycle
// - fu_ready   out  NUM_FU           FU i result accepted this cycle (valid&ready = transfer)
// - fu_wen     in   NUM_FU           result writes a destination register
// - fu_rd      in   NUM_FU x ADDR    destination register index
// - fu_data    in   NUM_FU x WIDTH   result value
// - fu_tag     in   NUM_FU x TAG_W   instruction tag
// - reg_write  out  1                register-file write enable
// - Write_reg  out  ADDR             register-file write index
// - Write_Data out  WIDTH            register-file write data
// - cdb_valid  out  1                CDB broadcast valid
// - cdb_tag    out  TAG_W            CDB tag
// - cdb_data   out  WIDTH            CDB data
// BEHAVIOUR
// - Reset: all buffers empty; rr pointer=0 (FU0 highest priority); every output register 0; fu_ready=all 1 from the first cycle after reset.
// - Buffer i: fu_ready[i] = !flush & (!full[i] | grant[i]). On valid&ready, capture {wen,rd,data,tag}; full set.
// - Granted and refilled in the same cycle: the buffer holds the new entry and stays full. Full throughput of one result per FU per cycle when it is the only requester.
// - Arbiter: combinational over full[]; search starts at ptr and wraps NUM_FU-1 -> 0; exactly one grant when any buffer is full.
// - Pointer: ptr <= (granted index + 1) mod NUM_FU on a grant; hold otherwise.
// - Output stage is registered. Granted entry appears on outputs in the next cycle:
//   - cdb_valid=1 for any granted entry.
//   - reg_write=1 only if wen=1 and rd!=0.
//   - Write_reg=rd, Write_Data=cdb_data=data, cdb_tag=tag.
// - Idle cycle (no grant): cdb_valid=0, reg_write=0, all data/index/tag outputs driven 0.
// - Latency: transfer edge at end of cycle N -> outputs valid in cycle N+2; each result broadcast exactly once, for one cycle.
// - flush=1:
//   - No transfers, no grant; all buffers cleared; output regs cleared at that edge.
//   - ptr is unchanged; results offered in that cycle are dropped.
// - rst has priority over flush; rst mid-operation discards all buffered results.
// - Ordering: no ordering guarantee between FUs; a given FU's results leave in acceptance order.
// STRUCTURE
// - core_pkg: wb_req_t struct {wen, rd[ADDR], data[WIDTH], tag[TAG_W]}; constants NUM_FU, TAG_W.
// - Sub-module rr_arbiter #(N): inputs req[N], ptr; output one-hot grant and grant index. Pointer register lives in the top level.
// - Top level: NUM_FU buffer instances via generate, pointer register, output register stage.
// TESTING
// - Reset: assert rst 2 cycles -> all outputs 0, fu_ready=4'b1111 after release.
// - Single FU: FU2 valid 1 cycle, wen=1 rd=5 data=32'hDEADBEEF tag=3 -> 2 cycles later one cycle of reg_write=1, Write_reg=5, Write_Data=DEADBEEF, cdb_tag=3.
// - Round-robin: all 4 FUs valid simultaneously with distinct tags 0..3 -> broadcasts tag0,1,2,3 on 4 consecutive cycles; fu_ready pattern as grants drain.
//   - Repeat the burst immediately -> order restarts at FU0 (ptr wrapped).
// - x0 / no-write: FU1 rd=0 wen=1 tag=7 -> cdb_valid=1, cdb_tag=7, reg_write=0; wen=0 rd=9 -> reg_write=0.
// - Contention: FU0 and FU3 valid every cycle for 10 cycles -> outputs alternate 0,3,0,3 with no idle cycle, no lost or duplicated tags.
// - Flush/reset: fill 3 buffers then flush 1 cycle -> fu_ready=0 that cycle, no broadcast afterwards.
//   - Repeat with rst instead of flush -> outputs 0 and ptr=0.

Source files
------------

// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared types and default sizes for the writeback / common-data-bus arbiter.
// The entry struct uses these defaults, so the top-level parameters must keep them.
package wb_cdb_arbiter_pkg;

  localparam int NUM_FU = 4;
  localparam int ADDR   = 5;
  localparam int WIDTH  = 32;
  localparam int TAG_W  = 6;

  typedef struct packed {
    logic             wen;
    logic [ADDR-1:0]  rd;
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } wb_req_t;

  // Register x0 is hardwired, so a write to index 0 is broadcast but not committed.
  function automatic logic writes_reg(input wb_req_t r);
    return r.wen && (r.rd != '0);
  endfunction

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// Functional-unit result bus plus the register-file write port and CDB broadcast.
// master = pipeline side (FUs, register file, RS/ROB); slave = the arbiter.
interface wb_cdb_arbiter_if
  import wb_cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = wb_cdb_arbiter_pkg::NUM_FU,
  parameter int ADDR   = wb_cdb_arbiter_pkg::ADDR,
  parameter int WIDTH  = wb_cdb_arbiter_pkg::WIDTH,
  parameter int TAG_W  = wb_cdb_arbiter_pkg::TAG_W
) ();

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0]            fu_ready;
  logic [NUM_FU-1:0]            fu_wen;
  logic [NUM_FU-1:0][ADDR-1:0]  fu_rd;
  logic [NUM_FU-1:0][WIDTH-1:0] fu_data;
  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;

  logic             reg_write;
  logic [ADDR-1:0]  Write_reg;
  logic [WIDTH-1:0] Write_Data;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [WIDTH-1:0] cdb_data;

  modport master (
    output fu_valid, fu_wen, fu_rd, fu_data, fu_tag,
    input  fu_ready,
    input  reg_write, Write_reg, Write_Data, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  fu_valid, fu_wen, fu_rd, fu_data, fu_tag,
    output fu_ready,
    output reg_write, Write_reg, Write_Data, cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/wb_cdb_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any_grant && req[k[PW-1:0]]) begin
        any_grant              = 1'b1;
        grant[k[PW-1:0]]       = 1'b1;
        grant_idx              = k[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: one-entry holding buffer per FU, round-robin grant, registered
// register-file write port and CDB broadcast (accept edge N -> outputs in cycle N+2).
module wb_cdb_arbiter
  import wb_cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = wb_cdb_arbiter_pkg::NUM_FU,
  parameter int ADDR   = wb_cdb_arbiter_pkg::ADDR,
  parameter int WIDTH  = wb_cdb_arbiter_pkg::WIDTH,
  parameter int TAG_W  = wb_cdb_arbiter_pkg::TAG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  wb_cdb_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] grant_raw;
  logic [NUM_FU-1:0] grant;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic              any_raw;
  logic              any_grant;
  wb_req_t           buf_q [NUM_FU];
  wb_req_t           sel;

  logic              vld_p1;
  logic              wr_p1;
  logic [ADDR-1:0]   rd_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [TAG_W-1:0]  tag_p1;

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .req       (full),
    .ptr       (ptr),
    .grant     (grant_raw),
    .grant_idx (grant_idx),
    .any_grant (any_raw)
  );

  // A flush cycle neither grants nor accepts, so the pointer and outputs see no winner.
  assign grant     = flush ? '0 : grant_raw;
  assign any_grant = any_raw && !flush;
  assign sel       = buf_q[grant_idx];

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_FU; i++)
      ready[i] = !flush && (!full[i] || grant[i]);
  end

  assign bus.fu_ready = ready;

  // Stage p0: per-FU holding buffers; a grant and a refill in one cycle keep the buffer full
  for (genvar g = 0; g < NUM_FU; g++) begin : g_buf
    logic take;
    assign take = bus.fu_valid[g] && ready[g];

    always_ff @(posedge clk) begin
      if (rst || flush)  full[g] <= 1'b0;
      else if (take)     full[g] <= 1'b1;
      else if (grant[g]) full[g] <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (take)
        buf_q[g] <= '{wen:  bus.fu_wen[g],
                      rd:   bus.fu_rd[g],
                      data: bus.fu_data[g],
                      tag:  bus.fu_tag[g]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (any_grant)
      ptr <= (grant_idx == PW'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Stage p1: registered write port / CDB; idle cycles drive every field to zero
  always_ff @(posedge clk) begin
    if (rst || flush || !any_grant) begin
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      tag_p1  <= '0;
    end else begin
      vld_p1  <= 1'b1;
      wr_p1   <= writes_reg(sel);
      rd_p1   <= sel.rd;
      data_p1 <= sel.data;
      tag_p1  <= sel.tag;
    end
  end

  assign bus.cdb_valid  = vld_p1;
  assign bus.reg_write  = wr_p1;
  assign bus.Write_reg  = rd_p1;
  assign bus.Write_Data = data_p1;
  assign bus.cdb_tag    = tag_p1;
  assign bus.cdb_data   = data_p1;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Bench for wb_cdb_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a behavioural model of buffers, rotating priority and output latency.
module tb_wb_cdb_arbiter;
  import wb_cdb_arbiter_pkg::*;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [5:0]  tag;
  } req_t;

  typedef struct {
    int          tag;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wr;
    int          cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  wb_cdb_arbiter_if #(.NUM_FU(4), .ADDR(5), .WIDTH(32), .TAG_W(6)) bus ();

  wb_cdb_arbiter #(.NUM_FU(4), .ADDR(5), .WIDTH(32), .TAG_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  req_t drvq [4][$];
  obs_t log_q [$];
  logic [3:0] last_ready;
  logic       last_vld;

  // Reference state: which FUs hold a result, what it is, who has priority, and what is on the outputs.
  bit   m_full [4];
  req_t m_ent [4];
  int   m_ptr = 0;
  bit   o_vld = 0;
  req_t o_ent = '{default: '0};
  bit   known = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic wen, input logic [4:0] rd, input logic [31:0] data, input logic [5:0] tag);
    req_t r;
    r.wen = wen; r.rd = rd; r.data = data; r.tag = tag;
    return r;
  endfunction

  task automatic step(input bit do_flush, input bit do_rst, input logic [3:0] vmask);
    int   gidx;
    logic [3:0] rdy;
    bit   in_v [4];
    req_t in_r [4];
    flush = do_flush;
    rst   = do_rst;
    for (int i = 0; i < 4; i++) begin
      in_v[i] = (drvq[i].size() > 0) && vmask[i];
      in_r[i] = in_v[i] ? drvq[i][0] : mk(1'($urandom), 5'($urandom), $urandom, 6'($urandom));
      bus.fu_valid[i] = in_v[i];
      bus.fu_wen[i]   = in_r[i].wen;
      bus.fu_rd[i]    = in_r[i].rd;
      bus.fu_data[i]  = in_r[i].data;
      bus.fu_tag[i]   = in_r[i].tag;
    end
    @(negedge clk);
    gidx = -1;
    if (!do_flush)
      for (int k = 0; k < 4; k++)
        if (gidx < 0 && m_full[(m_ptr + k) % 4]) gidx = (m_ptr + k) % 4;
    for (int i = 0; i < 4; i++)
      rdy[i] = !do_flush && (!m_full[i] || gidx == i);
    if (known) begin
      chk("fu_ready",   bus.fu_ready,   rdy);
      chk("cdb_valid",  bus.cdb_valid,  o_vld);
      chk("reg_write",  bus.reg_write,  o_vld && o_ent.wen && o_ent.rd != 0);
      chk("Write_reg",  bus.Write_reg,  o_ent.rd);
      chk("Write_Data", bus.Write_Data, o_ent.data);
      chk("cdb_tag",    bus.cdb_tag,    o_ent.tag);
      chk("cdb_data",   bus.cdb_data,   o_ent.data);
    end
    if (bus.cdb_valid === 1'b1)
      log_q.push_back('{tag: int'(bus.cdb_tag), data: bus.Write_Data, rd: bus.Write_reg,
                        wr: bus.reg_write, cyc: cyc});
    last_ready = bus.fu_ready;
    last_vld   = bus.cdb_valid;
    @(posedge clk);
    if (do_rst) begin
      for (int i = 0; i < 4; i++) m_full[i] = 0;
      m_ptr = 0; o_vld = 0; o_ent = mk(0, 0, 0, 0);
      known = 1;
    end else if (do_flush) begin
      for (int i = 0; i < 4; i++) m_full[i] = 0;
      o_vld = 0; o_ent = mk(0, 0, 0, 0);
    end else begin
      if (gidx >= 0) begin
        o_vld = 1; o_ent = m_ent[gidx]; m_full[gidx] = 0; m_ptr = (gidx + 1) % 4;
      end else begin
        o_vld = 0; o_ent = mk(0, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++)
        if (in_v[i] && rdy[i]) begin m_ent[i] = in_r[i]; m_full[i] = 1; end
    end
    for (int i = 0; i < 4; i++)
      if (in_v[i] && rdy[i]) void'(drvq[i].pop_front());
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'hF);
  endtask

  task automatic do_reset();
    step(0, 1, 4'h0);
    step(0, 1, 4'h0);
  endtask

  task automatic expect_tags(input string tag, input int base, input int n, input int tags[]);
    chk({tag, "_count"}, log_q.size() - base, n);
    if (log_q.size() >= base + n)
      for (int k = 0; k < n; k++) begin
        chk({tag, "_tag"}, log_q[base + k].tag, tags[k]);
        if (k > 0) chk({tag, "_gap"}, log_q[base + k].cyc - log_q[base + k - 1].cyc, 1);
      end
  endtask

  initial begin
    int base, c0;
    int tags[];

    // Reset, then the first released cycle must show empty outputs and all-ready
    do_reset();
    step(0, 0, 4'h0);
    chk("reset_ready", last_ready, 4'hF);
    chk("reset_vld", last_vld, 1'b0);

    // Single FU2 result surfaces two cycles after its accept edge
    base = log_q.size();
    c0 = cyc;
    drvq[2].push_back(mk(1, 5, 32'hDEADBEEF, 3));
    idle(4);
    chk("single_count", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      chk("single_tag",  log_q[base].tag,  3);
      chk("single_data", log_q[base].data, 32'hDEADBEEF);
      chk("single_rd",   log_q[base].rd,   5);
      chk("single_wr",   log_q[base].wr,   1);
      chk("single_lat",  log_q[base].cyc - c0, 2);
    end

    // Round-robin burst from a reset pointer, then an immediate second burst
    do_reset();
    base = log_q.size();
    for (int i = 0; i < 4; i++) drvq[i].push_back(mk(1, 5'(i + 1), 32'h100 + i, 6'(i)));
    for (int i = 0; i < 4; i++) drvq[i].push_back(mk(1, 5'(i + 9), 32'h200 + i, 6'(i + 4)));
    idle(12);
    tags = new[8];
    for (int k = 0; k < 8; k++) tags[k] = k;
    expect_tags("rr", base, 8, tags);

    // Writes to x0 and non-writing results are broadcast without a register write
    base = log_q.size();
    drvq[1].push_back(mk(1, 0, 32'h55, 7));
    drvq[1].push_back(mk(0, 9, 32'h66, 8));
    idle(6);
    chk("x0_count", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      chk("x0_tag",    log_q[base].tag, 7);
      chk("x0_wr",     log_q[base].wr, 0);
      chk("nowen_tag", log_q[base + 1].tag, 8);
      chk("nowen_wr",  log_q[base + 1].wr, 0);
      chk("nowen_rd",  log_q[base + 1].rd, 9);
    end

    // FU0 and FU3 streaming together alternate with no idle cycle
    do_reset();
    base = log_q.size();
    for (int k = 0; k < 10; k++) begin
      drvq[0].push_back(mk(1, 5'(k + 1), $urandom, 6'(k)));
      drvq[3].push_back(mk(1, 5'(k + 1), $urandom, 6'(32 + k)));
    end
    idle(26);
    tags = new[20];
    for (int k = 0; k < 20; k++) tags[k] = (k % 2 == 0) ? k / 2 : 32 + k / 2;
    expect_tags("contend", base, 20, tags);

    // Flush with three buffers full drops everything
    for (int i = 0; i < 3; i++) drvq[i].push_back(mk(1, 5'(i + 3), 32'hF0 + i, 6'(20 + i)));
    step(0, 0, 4'hF);
    base = log_q.size();
    step(1, 0, 4'hF);
    chk("flush_ready", last_ready, 4'h0);
    idle(4);
    chk("flush_drop", log_q.size() - base, 0);

    // Same with reset, after moving the pointer away from FU0
    drvq[1].push_back(mk(1, 4, 32'h77, 30));
    idle(4);
    for (int i = 0; i < 3; i++) drvq[i].push_back(mk(1, 5'(i + 3), 32'hE0 + i, 6'(24 + i)));
    step(0, 0, 4'hF);
    base = log_q.size();
    step(0, 1, 4'hF);
    step(0, 0, 4'h0);
    chk("rst_vld", last_vld, 1'b0);
    chk("rst_ready", last_ready, 4'hF);
    for (int i = 0; i < 4; i++) drvq[i].push_back(mk(1, 5'(i + 1), 32'h300 + i, 6'(40 + i)));
    idle(8);
    tags = new[4];
    for (int k = 0; k < 4; k++) tags[k] = 40 + k;
    expect_tags("rst_ptr", base, 4, tags);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (drvq[i].size() < 3 && $urandom_range(0, 99) < 45)
          drvq[i].push_back(mk(1'($urandom), 5'($urandom), $urandom, 6'($urandom)));
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2, 4'($urandom));
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
